// File: rtl/queue_ser_tx_pkg.sv
// rtl/queue_ser_tx_pkg.sv - shared queue definitions: FSM encoding and default sizing
package queue_ser_tx_pkg;

    localparam int DEF_W   = 8;
    localparam int DEF_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/queue_ser_tx_if.sv
// rtl/queue_ser_tx_if.sv - queue-drain and serial-line signal bundle
interface queue_ser_tx_if import queue_ser_tx_pkg::*; #(
    parameter int W = DEF_W
);
    logic         EN;
    logic         EMPTY;
    logic [W-1:0] DQ;
    logic         RD;
    logic         TXD;
    logic         BUSY;

    modport master (output EN, EMPTY, DQ, input RD, TXD, BUSY);
    modport slave  (input EN, EMPTY, DQ, output RD, TXD, BUSY);
endinterface

// File: rtl/tx_baud_cnt.sv
// rtl/tx_baud_cnt.sv - bit-period divider with clear input and terminal count
module tx_baud_cnt import queue_ser_tx_pkg::*; #(
    parameter int DIV = DEF_DIV
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clr_i,
    output logic tc_o
);
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tc_o = (cnt_q == 8'(DIV - 1));

    // restart the period on clear or at the end of each period
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end
    end

    // period counter register
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/queue_ser_tx.sv
// rtl/queue_ser_tx.sv - drains a FWFT queue onto a start/data/stop serial line
module queue_ser_tx import queue_ser_tx_pkg::*; #(
    parameter int W   = DEF_W,
    parameter int DIV = DEF_DIV
) (
    input  logic          CLK,
    input  logic          INIT_N,
    queue_ser_tx_if.slave bus
);
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    state_e       state_q;
    logic [W-1:0] sr_q;
    logic [W-1:0] sr_shift;
    logic [BW-1:0] bit_q;
    logic         txd_q;
    logic         busy_q;
    logic         tc;
    logic         pop;

    // a word is popped only from IDLE, so frames can never overlap
    assign pop      = INIT_N && (state_q == ST_IDLE) && bus.EN && !bus.EMPTY;
    assign sr_shift = sr_q >> 1;

    assign bus.RD   = pop;
    assign bus.TXD  = txd_q;
    assign bus.BUSY = busy_q;

    tx_baud_cnt #(.DIV(DIV)) u_baud (
        .clk_i    (CLK),
        .resetn_i (INIT_N),
        .clr_i    (state_q == ST_IDLE),
        .tc_o     (tc)
    );

    // frame FSM with shift register, bit counter and registered line outputs
    always_ff @(posedge CLK) begin
        if (!INIT_N) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        sr_q    <= bus.DQ;
                        state_q <= ST_START;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tc) begin
                        state_q <= ST_DATA;
                        txd_q   <= sr_q[0];
                    end
                end
                ST_DATA: begin
                    if (tc) begin
                        sr_q <= sr_shift;
                        if (bit_q == BW'(W - 1)) begin
                            bit_q   <= '0;
                            state_q <= ST_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            txd_q <= sr_shift[0];
                        end
                    end
                end
                ST_STOP: begin
                    if (tc) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_queue_ser_tx.sv
// tb/tb_queue_ser_tx.sv - self-checking bench for queue_ser_tx
module tb_queue_ser_tx;
    localparam int W    = 8;
    localparam int DIV  = 4;
    localparam int FLEN = (W + 2) * DIV;

    typedef struct {
        int   n;
        logic rd;
        logic txd;
        logic busy;
    } vec_t;

    logic clk = 1'b0;
    logic init_n = 1'b0;
    always #5 clk = ~clk;

    queue_ser_tx_if #(.W(W)) bus();
    queue_ser_tx #(.W(W), .DIV(DIV)) dut (
        .CLK    (clk),
        .INIT_N (init_n),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic         en_v = 1'b0;
    logic         rst_v = 1'b0;
    logic [W-1:0] q[$];
    logic [W-1:0] rx_q[$];
    int           pop_cyc[$];
    int           pops = 0;
    int           cyc = 0;

    int           k = -1;
    logic [W+1:0] frame = '1;
    int           rx_cnt = -1;
    logic [W-1:0] rx_sr = '0;

    logic s_rd, s_txd, s_busy;
    logic e_rd, e_txd, e_busy;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic [W-1:0] head;
        @(negedge clk);
        init_n    = rst_v;
        bus.EN    = en_v;
        bus.EMPTY = (q.size() == 0);
        head      = (q.size() != 0) ? q[0] : W'($urandom);
        bus.DQ    = head;
        #1;
        s_rd   = bus.RD;
        s_txd  = bus.TXD;
        s_busy = bus.BUSY;
        e_busy = (k >= 0);
        e_txd  = (k < 0) ? 1'b1 : frame[k / DIV];
        e_rd   = init_n && en_v && (q.size() != 0) && (k < 0);
        chk("rd", s_rd, e_rd);
        chk("txd", s_txd, e_txd);
        chk("busy", s_busy, e_busy);
        if (!init_n) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (s_txd == 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            if (rx_cnt % DIV == DIV / 2) begin
                if (rx_cnt / DIV >= 1 && rx_cnt / DIV <= W) begin
                    rx_sr[rx_cnt / DIV - 1] = s_txd;
                end else if (rx_cnt / DIV == W + 1) begin
                    if (s_txd) rx_q.push_back(rx_sr);
                    rx_cnt = -1;
                end
            end
        end
        @(posedge clk);
        if (s_rd) begin
            pops++;
            pop_cyc.push_back(cyc);
            if (q.size() != 0) void'(q.pop_front());
        end
        if (!init_n) begin
            k = -1;
        end else if (e_rd) begin
            frame = {1'b1, head, 1'b0};
            k = 0;
        end else if (k >= 0) begin
            k++;
            if (k == FLEN) k = -1;
        end
        cyc++;
    endtask

    task automatic wait_pop();
        int p0;
        p0 = pops;
        for (int i = 0; i < 5 && pops == p0; i++) cycle();
        chk("pop_seen", pops > p0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 * (FLEN + 1) && !(q.size() == 0 && k < 0); i++) cycle();
        chk("drain_done", (q.size() == 0 && k < 0), 1);
        for (int i = 0; i < 4; i++) cycle();
    endtask

    initial begin
        logic [W-1:0] a5;
        int p0;
        a5 = 8'hA5;
        tbl[0] = '{1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{DIV, 1'b0, 1'b0, 1'b1};
        for (int b = 0; b < W; b++) tbl[2 + b] = '{DIV, 1'b0, a5[b], 1'b1};
        tbl[10] = '{DIV, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{3, 1'b0, 1'b1, 1'b0};

        // reset with a word already waiting
        en_v = 1'b1;
        rst_v = 1'b0;
        q.push_back(8'hA5);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_rd", s_rd, 0);
            chk("rst_txd", s_txd, 1);
            chk("rst_busy", s_busy, 0);
        end
        rst_v = 1'b1;

        // single 0xA5 frame against the fixed waveform table
        p0 = pops;
        for (int r = 0; r < 12; r++) begin
            for (int j = 0; j < tbl[r].n; j++) begin
                cycle();
                chk($sformatf("tbl%0d_rd", r), s_rd, tbl[r].rd);
                chk($sformatf("tbl%0d_txd", r), s_txd, tbl[r].txd);
                chk($sformatf("tbl%0d_busy", r), s_busy, tbl[r].busy);
            end
        end
        chk("a5_pops", pops - p0, 1);
        chk("a5_rx_n", rx_q.size(), 1);
        if (rx_q.size() != 0) chk("a5_rx", rx_q[0], 8'hA5);

        // empty queue with enable held
        p0 = pops;
        for (int i = 0; i < 100; i++) cycle();
        chk("empty_no_rd", pops - p0, 0);

        // sixteen back-to-back words
        rx_q.delete();
        pop_cyc.delete();
        for (int i = 1; i <= 16; i++) q.push_back(W'(i));
        drain();
        chk("burst_pops", pop_cyc.size(), 16);
        chk("burst_rx_n", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) chk($sformatf("burst_rx%0d", i), rx_q[i], i + 1);
        for (int i = 1; i < 16 && i < pop_cyc.size(); i++)
            chk($sformatf("burst_gap%0d", i), pop_cyc[i] - pop_cyc[i-1], FLEN + 1);

        // enable dropped mid-frame
        rx_q.delete();
        q.push_back(8'h5A);
        q.push_back(8'hC3);
        p0 = pops;
        wait_pop();
        for (int i = 0; i < 9; i++) cycle();
        en_v = 1'b0;
        for (int i = 0; i < 60; i++) cycle();
        chk("endrop_pops", pops - p0, 1);
        chk("endrop_left", q.size(), 1);
        chk("endrop_rx_n", rx_q.size(), 1);
        if (rx_q.size() != 0) chk("endrop_rx", rx_q[0], 8'h5A);
        en_v = 1'b1;
        drain();

        // reset in the middle of frame 0x3C
        rx_q.delete();
        q.push_back(8'h3C);
        q.push_back(8'h77);
        wait_pop();
        for (int i = 0; i < 14; i++) cycle();
        rst_v = 1'b0;
        cycle();
        rst_v = 1'b1;
        cycle();
        chk("midrst_txd", s_txd, 1);
        chk("midrst_busy", s_busy, 0);
        drain();
        chk("midrst_rx_n", rx_q.size(), 1);
        if (rx_q.size() != 0) chk("midrst_rx", rx_q[0], 8'h77);

        // randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            en_v = ($urandom_range(0, 9) != 0);
            rst_v = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 24) == 0 && q.size() < 16) q.push_back(W'($urandom));
            cycle();
        end
        rst_v = 1'b1;
        en_v = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
